rijndael_shiftrows_pipe: RTL and testbench
==========================================

Name: rijndael_shiftrows_pipe

Overview:
- Registered, parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael round datapath.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns (128/192/256 bits), with per-transaction direction select.
- Valid/ready handshake on both sides; a 2-entry buffer (output register + skid register) sustains 1 state/cycle under backpressure.
- Sits between the SubBytes stage and the MixColumns stage of the round pipeline.

Parameters:
- NB, 4, number of state columns; legal values are 4, 6 and 8; any other value is a compile-time error.
- W, 32*NB, state width in bits; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  stage can accept an input state
- in_inv  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with in_data
- in_data  in  W  input state, column-major: row r, column c at bits [W-1-8*(4c+r) -: 8]
- flush  in  1  synchronous discard of all buffered states
- out_valid  out  1  output state valid
- out_ready  in  1  downstream accepts
- out_data  out  W  shifted state, same layout as in_data
- out_inv  out  1  in_inv carried with its state

Behaviour:
- Shift offsets (rows 1, 2, 3):
  - NB = 4 or 6: 1, 2, 3
  - NB = 8: 1, 3, 4
  - Row 0 is never shifted.
- Encrypt: out[r][c] = in[r][(c + s_r) mod NB].
- Decrypt: out[r][c] = in[r][(c - s_r) mod NB].
- The permutation is pure wiring. It is applied before the output register, so no arithmetic or width growth occurs.
- Storage: output register OR (data, inv, valid) and skid register SK (data, inv, valid).
- in_ready = !SK.valid, registered; no combinational path from out_ready to in_ready.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_valid = OR.valid; out_data and out_inv come from OR.
- Per clock edge:
  - OR empty, or OR transferring out: OR loads SK if SK.valid, else the permuted input if an input transfer occurs, else OR.valid clears.
  - OR full, not transferring, and an input transfer occurs: SK captures the permuted input.
  - SK drains into OR whenever OR frees.
  - Order is strictly FIFO.
- Latency: a state accepted at edge N is presented on out_data after edge N when OR was free. Throughput is 1/cycle while out_ready is held high.
- Simultaneous input and output transfer with OR full and SK empty: OR takes the new state, SK stays empty.
- Full (SK.valid = 1): in_ready = 0, and any in_valid is ignored.
- flush: clears OR.valid and SK.valid at the edge and overrides a simultaneous input transfer; in_ready = 1 the cycle after. Data registers are don't-care.
- Reset (also mid-operation): OR.valid = 0, SK.valid = 0, out_data = 0, out_inv = 0, in_ready = 0 during reset, 1 on the first cycle after reset deasserts. In-flight states are dropped.
- out_data/out_inv hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: SHIFTROWS_PARITY_EN.
- Enabled: adds in_par (in, NB*4, one even-parity bit per byte, same byte ordering as in_data), out_par (out, NB*4) and par_err (out, 1).
  - Parity bits are permuted and buffered alongside their bytes.
  - On each input transfer, any byte whose computed parity differs from its in_par bit sets par_err.
  - par_err is sticky; it is cleared only by rst, not by flush.
- Disabled: these ports do not exist and no parity logic is generated.

Decomposition:
- Shared package rijndael_pkg:
  - byte-index function idx(r, c)
  - shift-offset function shift_of(nb, r)
  - NB legality check constant
  - constants NB_128 = 4, NB_192 = 6, NB_256 = 8
- One combinational sub-module, rijndael_shiftrows_perm: parameter NB, inputs data and inv, output permuted data. The pipe instantiates it once on the input side. The parity option instantiates a second copy for the parity vector, treating each bit as a byte lane.

Test Plan:
- NB=4, inv=0, in_data d42711aee0bf98f1b8b45de51e415230 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 one cycle after acceptance, out_inv=0.
- NB=4, inv=1, in_data d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230, out_inv=1.
- NB=8, inv=0, in_data bytes 00..1F in layout order -> out_data begins 00 05 0E 13. NB=6, inv=1, with a round trip through an NB=6, inv=0 instance -> output equals input.
- Backpressure: out_ready=0 with 3 back-to-back inputs A, B, C -> A in OR, B in SK, in_ready=0, C held. Raise out_ready -> A, B, C emitted in order on consecutive cycles, no loss or duplication.
- Assert flush with OR and SK full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the flushed-cycle input is never emitted. Assert rst mid-stream -> all outputs zero, in_ready=0 during reset, 1 after deassertion.
- With SHIFTROWS_PARITY_EN: correct parity -> par_err stays 0 and out_par is correctly permuted. Flip one in_par bit -> par_err=1 after the edge, survives flush, clears on rst.

Source files
------------

// File: rtl/rijndael_pkg.sv
// Shared Rijndael helpers: state byte indexing, ShiftRows offsets per block width, NB legality.
// Pure constants/functions, no logic; the parity option SHIFTROWS_PARITY_EN does not affect this file.
package rijndael_pkg;

   localparam int NB_128 = 4;
   localparam int NB_192 = 6;
   localparam int NB_256 = 8;

   // Byte position of (row r, column c) counted from the MSB end of the state vector.
   function automatic int idx(input int r, input int c);
      return 4 * c + r;
   endfunction

   // The 256-bit block widens the row 2/3 offsets to 3/4; 128/192 use the row number.
   function automatic int shift_of(input int nb, input int r);
      if (r == 0) return 0;
      if (nb == NB_256 && r > 1) return r + 1;
      return r;
   endfunction

   function automatic bit nb_legal(input int nb);
      return (nb == NB_128) || (nb == NB_192) || (nb == NB_256);
   endfunction

endpackage

// File: rtl/rijndael_shiftrows_pipe_if.sv
// Handshake bundle for the ShiftRows stage; master = surrounding datapath, slave = the stage.
// Parity lanes exist only when SHIFTROWS_PARITY_EN is defined.
interface rijndael_shiftrows_pipe_if
   import rijndael_pkg::*;
#(
   parameter int NB = NB_128
);
   localparam int W = 32 * NB;

   logic          in_valid;
   logic          in_ready;
   logic          in_inv;
   logic [W-1:0]  in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_inv;

`ifdef SHIFTROWS_PARITY_EN
   logic [4*NB-1:0] in_par;
   logic [4*NB-1:0] out_par;
   logic            par_err;

   modport master (
      output in_valid, in_inv, in_data, flush, out_ready, in_par,
      input  in_ready, out_valid, out_data, out_inv, out_par, par_err
   );
   modport slave (
      input  in_valid, in_inv, in_data, flush, out_ready, in_par,
      output in_ready, out_valid, out_data, out_inv, out_par, par_err
   );
`else
   modport master (
      output in_valid, in_inv, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_inv
   );
   modport slave (
      input  in_valid, in_inv, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_inv
   );
`endif

endinterface

// File: rtl/rijndael_shiftrows_perm.sv
// Combinational ShiftRows/InvShiftRows lane permutation; zero latency, no handshake.
// LANE is the lane width: 8 for state bytes, 1 for the per-byte parity vector.
module rijndael_shiftrows_perm
   import rijndael_pkg::*;
#(
   parameter int NB   = NB_128,
   parameter int LANE = 8,
   localparam int LW  = 4 * NB * LANE
) (
   input  logic [LW-1:0] data_i,
   input  logic          inv_i,
   output logic [LW-1:0] data_o
);

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int DST = idx(r, c);
         localparam int ENC = idx(r, (c + shift_of(NB, r)) % NB);
         localparam int DEC = idx(r, (c + NB - shift_of(NB, r)) % NB);

         assign data_o[LW-1-LANE*DST -: LANE] = inv_i ? data_i[LW-1-LANE*DEC -: LANE]
                                                      : data_i[LW-1-LANE*ENC -: LANE];
      end
   end

endmodule

// File: rtl/rijndael_shiftrows_pipe.sv
// Registered ShiftRows stage: 1-cycle latency, 1 state/cycle, output + skid register so in_ready never depends on out_ready.
// SHIFTROWS_PARITY_EN adds per-byte even parity carried with the state and a sticky par_err.
module rijndael_shiftrows_pipe
   import rijndael_pkg::*;
#(
   parameter int NB = NB_128
) (
   input  logic                      clk,
   input  logic                      rst,
   rijndael_shiftrows_pipe_if.slave  bus
);
   localparam int W = 32 * NB;

   if (!nb_legal(NB)) begin : g_nb_check
      $error("rijndael_shiftrows_pipe: NB must be 4, 6 or 8");
   end

   typedef struct packed {
      logic [W-1:0]    dat;
      logic            inv;
`ifdef SHIFTROWS_PARITY_EN
      logic [4*NB-1:0] par;
`endif
   } ent_t;

   ent_t          in_ent;
   ent_t          or_q, or_d;
   ent_t          sk_q, sk_d;
   logic          or_vld_q, or_vld_d;
   logic          sk_vld_q, sk_vld_d;
   logic          in_rdy;
   logic          in_xfer;
   logic          or_free;
   logic [W-1:0]  perm_dat;

   rijndael_shiftrows_perm #(.NB(NB), .LANE(8)) u_perm_dat (
      .data_i (bus.in_data),
      .inv_i  (bus.in_inv),
      .data_o (perm_dat)
   );

   assign in_ent.dat = perm_dat;
   assign in_ent.inv = bus.in_inv;

   // Readiness depends only on the skid flag (and reset), never on out_ready.
   assign in_rdy  = !sk_vld_q && !rst;
   assign in_xfer = bus.in_valid && in_rdy;
   assign or_free = !or_vld_q || bus.out_ready;

   always_comb begin
      or_d     = or_q;
      sk_d     = sk_q;
      or_vld_d = or_vld_q;
      sk_vld_d = sk_vld_q;
      if (bus.flush) begin
         or_vld_d = 1'b0;
         sk_vld_d = 1'b0;
      end else if (or_free) begin
         if (sk_vld_q) begin
            or_d     = sk_q;
            or_vld_d = 1'b1;
            sk_vld_d = 1'b0;
         end else if (in_xfer) begin
            or_d     = in_ent;
            or_vld_d = 1'b1;
         end else begin
            or_vld_d = 1'b0;
         end
      end else if (in_xfer) begin
         sk_d     = in_ent;
         sk_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         or_q     <= '0;
         sk_q     <= '0;
         or_vld_q <= 1'b0;
         sk_vld_q <= 1'b0;
      end else begin
         or_q     <= or_d;
         sk_q     <= sk_d;
         or_vld_q <= or_vld_d;
         sk_vld_q <= sk_vld_d;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = or_vld_q;
   assign bus.out_data  = or_q.dat;
   assign bus.out_inv   = or_q.inv;

`ifdef SHIFTROWS_PARITY_EN
   logic [4*NB-1:0] perm_par;
   logic [4*NB-1:0] par_calc;
   logic            par_err_q, par_err_d;

   rijndael_shiftrows_perm #(.NB(NB), .LANE(1)) u_perm_par (
      .data_i (bus.in_par),
      .inv_i  (bus.in_inv),
      .data_o (perm_par)
   );

   assign in_ent.par = perm_par;

   always_comb begin
      par_calc = '0;
      for (int i = 0; i < 4 * NB; i++) begin
         par_calc[4*NB-1-i] = ^bus.in_data[W-1-8*i -: 8];
      end
   end

   // Sticky across flush; only reset clears it.
   assign par_err_d = par_err_q || (in_xfer && (par_calc != bus.in_par));

   always_ff @(posedge clk) begin
      if (rst) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end

   assign bus.out_par = or_q.par;
   assign bus.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_rijndael_shiftrows_pipe.sv
// Scoreboarded bench: directed ShiftRows vectors, backpressure, flush and reset; NB=8 and NB=6 round trip.
// Define SHIFTROWS_PARITY_EN to also exercise the parity lanes.
module tb_rijndael_shiftrows_pipe;
   import rijndael_pkg::*;

   localparam logic [127:0] AES_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] AES_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] SEQ_IN  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_ENC = 128'h00050a0f04090e03080d02070c01060b;
   localparam logic [127:0] SEQ_DEC = 128'h000d0a0704010e0b0805020f0c090603;
   localparam logic [255:0] EXP8    = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

   typedef struct {
      logic [127:0] dat;
      logic         inv;
`ifdef SHIFTROWS_PARITY_EN
      logic [15:0]  par;
`endif
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t q4[$];
   exp_t mon_e;
   logic bad_par = 1'b0;

   always #5 clk = ~clk;

   rijndael_shiftrows_pipe_if #(.NB(4)) if4 ();
   rijndael_shiftrows_pipe_if #(.NB(8)) if8 ();
   rijndael_shiftrows_pipe_if #(.NB(6)) if6a ();
   rijndael_shiftrows_pipe_if #(.NB(6)) if6b ();

   rijndael_shiftrows_pipe #(.NB(4)) u_dut4  (.clk(clk), .rst(rst), .bus(if4));
   rijndael_shiftrows_pipe #(.NB(8)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
   rijndael_shiftrows_pipe #(.NB(6)) u_dut6a (.clk(clk), .rst(rst), .bus(if6a));
   rijndael_shiftrows_pipe #(.NB(6)) u_dut6b (.clk(clk), .rst(rst), .bus(if6b));

   assign if6b.in_valid  = if6a.out_valid;
   assign if6b.in_data   = if6a.out_data;
   assign if6a.out_ready = if6b.in_ready;
`ifdef SHIFTROWS_PARITY_EN
   assign if6b.in_par    = if6a.out_par;

   function automatic logic [31:0] par_of(input logic [255:0] d, input int nb);
      logic [31:0] p = '0;
      for (int i = 0; i < 4 * nb; i++) p[4*nb-1-i] = ^d[32*nb-1-8*i -: 8];
      return p;
   endfunction
`endif

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; pushes the expectation once the state is accepted.
   task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] e);
      exp_t x;
      logic rdy;
      int   n = 0;
`ifdef SHIFTROWS_PARITY_EN
      logic [31:0] pv;
      pv = par_of({128'b0, d}, 4);
      if4.in_par = pv[15:0] ^ (bad_par ? 16'h0100 : 16'h0000);
      pv = par_of({128'b0, e}, 4);
      x.par = pv[15:0];
`endif
      if4.in_data  = d;
      if4.in_inv   = inv;
      if4.in_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = if4.in_ready;
         tick();
         n++;
      end while (!rdy && n < 50);
      if (rdy) begin
         x.dat = e;
         x.inv = inv;
         q4.push_back(x);
      end else begin
         chk("send_timeout", 256'(rdy), 256'(1));
      end
      if4.in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && if4.out_valid && if4.out_ready) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL out4_extra got %h inv %0b", if4.out_data, if4.out_inv);
         end else begin
            mon_e = q4.pop_front();
            if (if4.out_data !== mon_e.dat || if4.out_inv !== mon_e.inv) begin
               errors++;
               $display("FAIL out4_data got %h/%0b want %h/%0b",
                        if4.out_data, if4.out_inv, mon_e.dat, mon_e.inv);
            end
`ifdef SHIFTROWS_PARITY_EN
            chk("out4_par", 256'(if4.out_par), 256'(mon_e.par));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] d8;
      logic [191:0] x6;
      int           n;
`ifdef SHIFTROWS_PARITY_EN
      logic [31:0]  pv;
`endif
      rst = 1'b1;
      if4.in_valid = 1'b0;  if4.in_inv = 1'b0;  if4.in_data = '0;  if4.flush = 1'b0;  if4.out_ready = 1'b1;
      if8.in_valid = 1'b0;  if8.in_inv = 1'b0;  if8.in_data = '0;  if8.flush = 1'b0;  if8.out_ready = 1'b1;
      if6a.in_valid = 1'b0; if6a.in_inv = 1'b0; if6a.in_data = '0; if6a.flush = 1'b0;
      if6b.in_inv = 1'b1;   if6b.flush = 1'b0;  if6b.out_ready = 1'b1;
`ifdef SHIFTROWS_PARITY_EN
      if4.in_par = '0; if8.in_par = '0; if6a.in_par = '0;
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 256'(if4.out_valid), 256'(0));
      chk("rst_out_data",  256'(if4.out_data),  256'(0));
      chk("rst_out_inv",   256'(if4.out_inv),   256'(0));
      chk("rst_in_ready",  256'(if4.in_ready),  256'(0));
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 256'(if4.in_ready), 256'(1));
`ifdef SHIFTROWS_PARITY_EN
      chk("rst_par_err", 256'(if4.par_err), 256'(0));
`endif
      tick();

      send(AES_IN, 1'b0, AES_OUT);
      @(negedge clk);
      chk("latency_out_valid", 256'(if4.out_valid), 256'(1));
      tick();
      send(AES_OUT, 1'b1, AES_IN);
      send(SEQ_IN, 1'b0, SEQ_ENC);
      send(SEQ_IN, 1'b1, SEQ_DEC);
      repeat (3) tick();

      // A into OR, B into SK, C held until out_ready rises.
      if4.out_ready = 1'b0;
      send(AES_IN, 1'b0, AES_OUT);
      send(SEQ_IN, 1'b1, SEQ_DEC);
      fork
         send(SEQ_IN, 1'b0, SEQ_ENC);
         begin
            @(negedge clk);
            chk("bp_in_ready", 256'(if4.in_ready), 256'(0));
            chk("bp_out_valid", 256'(if4.out_valid), 256'(1));
            chk("bp_hold_data0", 256'(if4.out_data), 256'(AES_OUT));
            @(negedge clk);
            chk("bp_hold_data1", 256'(if4.out_data), 256'(AES_OUT));
            chk("bp_hold_inv", 256'(if4.out_inv), 256'(0));
            tick();
            if4.out_ready = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk("bp_drain_valid", 256'(if4.out_valid), 256'(1));
            end
         end
      join
      repeat (3) tick();

      // Flush with both registers full and a competing input.
      if4.out_ready = 1'b0;
      send(SEQ_IN, 1'b0, SEQ_ENC);
      send(AES_IN, 1'b0, AES_OUT);
      if4.in_data  = AES_OUT;
      if4.in_inv   = 1'b1;
      if4.in_valid = 1'b1;
      if4.flush    = 1'b1;
      tick();
      if4.flush    = 1'b0;
      if4.in_valid = 1'b0;
      q4.delete();
      @(negedge clk);
      chk("flush_out_valid", 256'(if4.out_valid), 256'(0));
      chk("flush_in_ready",  256'(if4.in_ready),  256'(1));
      tick();
      if4.out_ready = 1'b1;
      repeat (4) tick();

      // Reset mid-stream.
      if4.out_ready = 1'b0;
      send(AES_IN, 1'b0, AES_OUT);
      send(SEQ_IN, 1'b1, SEQ_DEC);
      rst = 1'b1;
      if4.in_valid = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready0", 256'(if4.in_ready), 256'(0));
      tick();
      if4.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 256'(if4.out_valid), 256'(0));
      chk("mid_rst_out_data",  256'(if4.out_data),  256'(0));
      chk("mid_rst_out_inv",   256'(if4.out_inv),   256'(0));
      chk("mid_rst_in_ready1", 256'(if4.in_ready),  256'(0));
      q4.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready_after", 256'(if4.in_ready), 256'(1));
      tick();
      if4.out_ready = 1'b1;
      send(AES_OUT, 1'b1, AES_IN);
      repeat (3) tick();

`ifdef SHIFTROWS_PARITY_EN
      chk("par_err_clean", 256'(if4.par_err), 256'(0));
      if4.out_ready = 1'b0;
      bad_par = 1'b1;
      send(SEQ_IN, 1'b0, SEQ_ENC);
      bad_par = 1'b0;
      @(negedge clk);
      chk("par_err_set", 256'(if4.par_err), 256'(1));
      tick();
      if4.flush = 1'b1;
      tick();
      if4.flush = 1'b0;
      q4.delete();
      @(negedge clk);
      chk("par_err_after_flush", 256'(if4.par_err), 256'(1));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("par_err_after_rst", 256'(if4.par_err), 256'(0));
      tick();
      if4.out_ready = 1'b1;
`endif

      // NB=8: bytes 00..1F in layout order.
      for (int i = 0; i < 32; i++) d8[255-8*i -: 8] = 8'(i);
      if8.in_data  = d8;
      if8.in_inv   = 1'b0;
`ifdef SHIFTROWS_PARITY_EN
      pv = par_of(d8, 8);
      if8.in_par = pv;
`endif
      if8.in_valid = 1'b1;
      tick();
      if8.in_valid = 1'b0;
      @(negedge clk);
      chk("nb8_out_valid", 256'(if8.out_valid), 256'(1));
      chk("nb8_out_data",  if8.out_data,        EXP8);
      chk("nb8_out_inv",   256'(if8.out_inv),   256'(0));
      tick();

      // NB=6: encrypt stage feeding a decrypt stage must reproduce the input.
      for (int i = 0; i < 24; i++) x6[191-8*i -: 8] = 8'(160 + i);
      if6a.in_data  = x6;
      if6a.in_inv   = 1'b0;
`ifdef SHIFTROWS_PARITY_EN
      pv = par_of({64'b0, x6}, 6);
      if6a.in_par = pv[23:0];
`endif
      if6a.in_valid = 1'b1;
      tick();
      if6a.in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!if6b.out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("nb6_rt_valid", 256'(if6b.out_valid), 256'(1));
      chk("nb6_rt_data",  256'(if6b.out_data),  256'(x6));
      chk("nb6_rt_inv",   256'(if6b.out_inv),   256'(1));
      tick();

      n = 0;
      while (q4.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk("scoreboard_empty", 256'(q4.size()), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
